// File: rtl/span_pkg.sv
// Shared definitions for the SPAN margin engine: register map, status bits,
// FSM states and scenario sweep constants.
package span_pkg;

    localparam logic [5:0] OFF_CTRL        = 6'd0;
    localparam logic [5:0] OFF_PSR         = 6'd1;
    localparam logic [5:0] OFF_SPREAD_RATE = 6'd2;
    localparam logic [5:0] OFF_MARGIN_LO   = 6'd3;
    localparam logic [5:0] OFF_MARGIN_HI   = 6'd4;
    localparam logic [5:0] OFF_SCAN_RISK   = 6'd5;
    localparam logic [5:0] OFF_POS_BASE    = 6'd8;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;
    localparam int ST_SAT  = 3;

    localparam int N_SCEN     = 9;
    localparam int SCAN_SHIFT = 2;
    localparam int M_MAX      = (N_SCEN - 1) / 2;
    localparam int SCAN_W     = 48;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_SCAN,
        S_FINAL
    } state_t;

endpackage

// File: rtl/span_scan_unit.sv
// One price scenario per enabled cycle: loss for move m, plus running
// maximum of the losses (floored at zero).
module span_scan_unit
    import span_pkg::*;
#(
    parameter int NET_W = 23
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [NET_W-1:0]  net,
    input  logic        [15:0]       psr,
    input  logic signed [3:0]        m,
    output logic signed [SCAN_W-1:0] risk
);

    logic signed [20:0]       prod;
    logic signed [20:0]       move;
    logic signed [SCAN_W-1:0] loss;

    always_comb begin
        prod = 21'($signed({1'b0, psr})) * 21'(m);
        move = prod >>> SCAN_SHIFT;
        loss = -(SCAN_W'(net) * SCAN_W'(move));
    end

    // Starting from zero makes the result max(0, max loss)
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            risk <= '0;
        end else if (en && (loss > risk)) begin
            risk <= loss;
        end
    end

endmodule

// File: rtl/span_margin_engine.sv
// SPAN initial-margin engine on the chipselect/offset register bus.
// Optional done interrupt under SPAN_MARGIN_IRQ_EN.
module span_margin_engine
    import span_pkg::*;
#(
    parameter int N_POS    = 8,
    parameter int POS_W    = 16,
    parameter int MARGIN_W = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [5:0]  offset,
    input  logic [15:0] writeData,
    output logic [15:0] readData,
    output logic        busy,
    output logic        irq
);

    localparam int ACC_W = POS_W + 6;
    localparam int ACC_X = ACC_W + 1;
    localparam int SPR_W = ACC_W + 8;
    localparam int IDX_W = (N_POS > 1) ? $clog2(N_POS) : 1;

    state_t state_q, state_d;

    logic [15:0]             psr_q;
    logic [7:0]              rate_q;
    logic signed [POS_W-1:0] pos_q [N_POS];
    logic [ACC_W-1:0]        longs_q, shorts_q;
    logic [IDX_W-1:0]        idx_q;
    logic signed [3:0]       m_q;
    logic [MARGIN_W-1:0]     margin_q;
    logic [15:0]             risk_q;
    logic                    done_q, err_q, sat_q;

    logic             wr, rd, ctrl_wr, clr_cmd, start;
    logic             is_pos, cfg_wr;
    logic [IDX_W-1:0] pidx;
    logic             acc_en, scan_en, fin_en;
    logic             acc_last, scan_last;

    logic signed [ACC_X-1:0]  pext;
    logic signed [ACC_X-1:0]  net;
    logic signed [SCAN_W-1:0] risk;
    logic [ACC_W-1:0]         mn;
    logic [SPR_W-1:0]         spread;
    logic [SCAN_W-1:0]        total;
    logic                     sat_now;
    logic [31:0]              mext;
    logic [15:0]              status;
    logic [15:0]              rdata;

    always_comb begin
        wr      = chipselect && write;
        rd      = chipselect && read;
        ctrl_wr = wr && (offset == OFF_CTRL);
        clr_cmd = ctrl_wr && writeData[1];
        is_pos  = (int'(offset) >= int'(OFF_POS_BASE)) &&
                  (int'(offset) < int'(OFF_POS_BASE) + N_POS);
        pidx    = IDX_W'(offset - OFF_POS_BASE);
        cfg_wr  = wr && ((offset == OFF_PSR) ||
                  (offset == OFF_SPREAD_RATE) || is_pos);
        busy    = (state_q != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        acc_en    = 1'b0;
        scan_en   = 1'b0;
        fin_en    = 1'b0;
        acc_last  = (idx_q == IDX_W'(N_POS - 1));
        scan_last = (m_q == 4'(M_MAX));
        unique case (state_q)
            S_IDLE: begin
                if (ctrl_wr && writeData[0]) begin
                    start   = 1'b1;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                acc_en = 1'b1;
                if (acc_last) state_d = S_SCAN;
            end
            S_SCAN: begin
                scan_en = 1'b1;
                if (scan_last) state_d = S_FINAL;
            end
            S_FINAL: begin
                fin_en  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pext    = ACC_X'(pos_q[idx_q]);
        net     = $signed({1'b0, longs_q}) - $signed({1'b0, shorts_q});
        mn      = (longs_q < shorts_q) ? longs_q : shorts_q;
        spread  = SPR_W'(mn) * SPR_W'(rate_q);
        total   = $unsigned(risk) + SCAN_W'(spread);
        sat_now = |total[SCAN_W-1:MARGIN_W];
    end

    span_scan_unit #(
        .NET_W (ACC_X)
    ) u_scan (
        .clk   (clk),
        .reset (reset),
        .clr   (start),
        .en    (scan_en),
        .net   (net),
        .psr   (psr_q),
        .m     (m_q),
        .risk  (risk)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            psr_q    <= '0;
            rate_q   <= '0;
            longs_q  <= '0;
            shorts_q <= '0;
            idx_q    <= '0;
            m_q      <= '0;
            margin_q <= '0;
            risk_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            sat_q    <= 1'b0;
            for (int i = 0; i < N_POS; i++) pos_q[i] <= '0;
        end else begin
            if (wr && !busy) begin
                if (offset == OFF_PSR) psr_q <= writeData;
                if (offset == OFF_SPREAD_RATE) rate_q <= writeData[7:0];
                if (is_pos) pos_q[pidx] <= writeData[POS_W-1:0];
            end
            if (clr_cmd) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
                sat_q  <= 1'b0;
            end
            if (cfg_wr && busy) err_q <= 1'b1;
            if (start) begin
                done_q   <= 1'b0;
                longs_q  <= '0;
                shorts_q <= '0;
                idx_q    <= '0;
                m_q      <= -4'(M_MAX);
            end
            // Shorts add |pos|, i.e. subtract the negative value
            if (acc_en) begin
                idx_q <= idx_q + IDX_W'(1);
                if (pext > 0) longs_q <= longs_q + pext[ACC_W-1:0];
                else if (pext < 0) shorts_q <= shorts_q - pext[ACC_W-1:0];
            end
            if (scan_en) m_q <= m_q + 4'sd1;
            if (fin_en) begin
                margin_q <= sat_now ? '1 : total[MARGIN_W-1:0];
                risk_q   <= risk[15:0];
                done_q   <= 1'b1;
                if (sat_now) sat_q <= 1'b1;
            end
        end
    end

    always_comb begin
        mext           = 32'(margin_q);
        status         = '0;
        status[ST_BUSY] = busy;
        status[ST_DONE] = done_q;
        status[ST_ERR]  = err_q;
        status[ST_SAT]  = sat_q;
        rdata          = '0;
        unique case (1'b1)
            offset == OFF_CTRL:        rdata = status;
            offset == OFF_PSR:         rdata = psr_q;
            offset == OFF_SPREAD_RATE: rdata = {8'd0, rate_q};
            offset == OFF_MARGIN_LO:   rdata = mext[15:0];
            offset == OFF_MARGIN_HI:   rdata = mext[31:16];
            offset == OFF_SCAN_RISK:   rdata = risk_q;
            is_pos:                    rdata = 16'(pos_q[pidx]);
            default:                   rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readData <= '0;
        end else if (rd) begin
            readData <= rdata;
        end
    end

`ifdef SPAN_MARGIN_IRQ_EN
    logic irq_q;

    // A completing run wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else if (fin_en) begin
            irq_q <= 1'b1;
        end else if (clr_cmd || (rd && offset == OFF_CTRL)) begin
            irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_span_margin_engine.sv
// Directed self-checking bench for span_margin_engine.
// Expected values are hand-computed from the margin formulas.
module tb_span_margin_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [5:0]  offset;
    logic [15:0] writeData;
    logic [15:0] readData;
    logic        busy;
    logic        irq;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc;

    always #5 clk = ~clk;

    span_margin_engine #(
        .N_POS    (8),
        .POS_W    (16),
        .MARGIN_W (24)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .offset     (offset),
        .writeData  (writeData),
        .readData   (readData),
        .busy       (busy),
        .irq        (irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [5:0] a, input logic [15:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write      = 1'b1;
        offset     = a;
        writeData  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] a,
                          input logic [15:0] exp);
        @(negedge clk);
        chipselect = 1'b1;
        read       = 1'b1;
        offset     = a;
        @(negedge clk);
        chipselect = 1'b0;
        read       = 1'b0;
        check_eq(tag, {16'd0, readData}, {16'd0, exp});
    endtask

    task automatic wait_idle(output int c);
        c = 0;
        while (busy && c < 200) begin
            c++;
            @(negedge clk);
        end
        check_eq("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic run(output int c);
        bus_wr(6'd0, 16'h0001);
        wait_idle(c);
    endtask

    initial begin
        reset      = 1'b1;
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        offset     = '0;
        writeData  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_irq", {31'd0, irq}, 32'd0);
        rd_chk("rst_status", 6'd0, 16'h0000);
        rd_chk("rst_psr", 6'd1, 16'h0000);
        rd_chk("rst_mlo", 6'd3, 16'h0000);
        rd_chk("rst_pos0", 6'd8, 16'h0000);

        // All positions zero
        bus_wr(6'd1, 16'd100);
        run(cyc);
        check_eq("t1_cycles", cyc, 32'd18);
`ifdef SPAN_MARGIN_IRQ_EN
        check_eq("t1_irq_set", {31'd0, irq}, 32'd1);
        rd_chk("t1_status", 6'd0, 16'h0002);
        check_eq("t1_irq_clr", {31'd0, irq}, 32'd0);
`else
        check_eq("t1_irq_off", {31'd0, irq}, 32'd0);
        rd_chk("t1_status", 6'd0, 16'h0002);
`endif
        rd_chk("t1_mlo", 6'd3, 16'h0000);

        // Single long, no spread
        bus_wr(6'd8, 16'd10);
        run(cyc);
        rd_chk("t2_risk", 6'd5, 16'd1000);
        rd_chk("t2_mlo", 6'd3, 16'd1000);
        rd_chk("t2_mhi", 6'd4, 16'd0);

        // Long + short with spread
        bus_wr(6'd9, 16'hFFFC);
        bus_wr(6'd2, 16'd5);
        rd_chk("t3_pos1", 6'd9, 16'hFFFC);
        rd_chk("t3_rate", 6'd2, 16'd5);
        run(cyc);
        rd_chk("t3_risk", 6'd5, 16'd600);
        rd_chk("t3_mlo", 6'd3, 16'd620);

        // Floor rounding of the price move
        bus_wr(6'd8, 16'd1);
        bus_wr(6'd9, 16'd0);
        bus_wr(6'd2, 16'd0);
        bus_wr(6'd1, 16'd3);
        run(cyc);
        rd_chk("t4_mlo", 6'd3, 16'd3);
        rd_chk("t4_status", 6'd0, 16'h0002);

        // Saturation
        for (int i = 0; i < 8; i++) bus_wr(6'(8 + i), 16'h7FFF);
        bus_wr(6'd1, 16'hFFFF);
        run(cyc);
        rd_chk("t5_mlo", 6'd3, 16'hFFFF);
        rd_chk("t5_mhi", 6'd4, 16'h00FF);
        rd_chk("t5_status", 6'd0, 16'h000A);
        bus_wr(6'd0, 16'h0002);
        rd_chk("t5_clr", 6'd0, 16'h0000);
        rd_chk("unmapped", 6'd6, 16'h0000);

        // Writes while busy are dropped and flagged
        bus_wr(6'd8, 16'd10);
        bus_wr(6'd9, 16'hFFFC);
        for (int i = 2; i < 8; i++) bus_wr(6'(8 + i), 16'd0);
        bus_wr(6'd1, 16'd100);
        bus_wr(6'd2, 16'd5);
        bus_wr(6'd0, 16'h0001);
        bus_wr(6'd1, 16'd7);
        bus_wr(6'd0, 16'h0001);
        wait_idle(cyc);
        rd_chk("t6_status", 6'd0, 16'h0006);
        rd_chk("t6_psr", 6'd1, 16'd100);
        rd_chk("t6_mlo", 6'd3, 16'd620);

        // Reset in the middle of ACCUM
        bus_wr(6'd0, 16'h0003);
        @(negedge clk);
        check_eq("t7_busy_run", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("t7_busy_rst", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        rd_chk("t7_status", 6'd0, 16'h0000);
        rd_chk("t7_mlo", 6'd3, 16'h0000);
        rd_chk("t7_psr", 6'd1, 16'h0000);
        check_eq("t7_irq", {31'd0, irq}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
